// File: rtl/uart_pkg.sv
// uart_pkg -- shared constants for the UART frame parser and its bench.
//   state_t      : parser FSM encoding
//   ERR_*        : err_code values reported with frame_err
//   SOF_DEFAULT  : default start-of-frame byte
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_LEN = 3'd1,
        ST_GET_PL  = 3'd2,
        ST_GET_CHK = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_buf.sv
// frame_buf -- payload store for one frame: DEPTH x 8 bits,
// synchronous write, asynchronous read. Contents are not reset.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write byte
//   rd_addr  : read address
//   rd_data  : byte at rd_addr (combinational)
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser -- parses SOF, LEN, payload[LEN], CHK frames from a
// byte-strobe UART receiver, checks CHK = XOR(LEN, payload), and replays
// accepted payloads over a valid/ready stream.
//   clk, rst          : clock, async active-high reset
//   rx_done_tick      : received byte strobe
//   rx_data           : received byte
//   pl_valid/pl_data  : payload stream out
//   pl_last           : final payload byte of the frame
//   pl_ready          : consumer accept
//   frame_ok          : pulse, frame accepted and queued
//   frame_err         : pulse, frame discarded, cause in err_code
//   err_code          : 1=bad length, 2=checksum, 3=timeout (held)
//   busy              : FSM not idle
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF         = SOF_DEFAULT,
    parameter int         TIMEOUT_CYC = 52160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       pl_valid,
    output logic [7:0] pl_data,
    output logic       pl_last,
    input  logic       pl_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    // LW holds 0..MAX_LEN so the write index can step one past the last byte.
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] TERM = IW'(TIMEOUT_CYC - 1);

    state_t          state, state_nxt;
    logic [LW-1:0]   len, idx, rd_idx;
    logic [7:0]      chk;
    logic [IW-1:0]   idle_cnt;
    logic [7:0]      buf_q;

    logic            ld_len, wr_en, ok_set, err_set, cnt_clr, cnt_inc, rd_adv;
    logic [1:0]      err_cause;

    frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (idx[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (buf_q)
    );

    assign pl_valid = (state == ST_SEND);
    // Gate the read port so pl_data is 0 outside SEND (the buffer is never reset).
    assign pl_data  = pl_valid ? buf_q : 8'h00;
    assign pl_last  = pl_valid && (rd_idx == len - LW'(1));
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_len    = 1'b0;
        wr_en     = 1'b0;
        ok_set    = 1'b0;
        err_set   = 1'b0;
        err_cause = err_code;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        rd_adv    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_done_tick && rx_data == SOF) state_nxt = ST_GET_LEN;
            end
            ST_GET_LEN, ST_GET_PL, ST_GET_CHK: begin
                // A byte arriving on the terminal count wins over the timeout.
                if (rx_done_tick) begin
                    cnt_clr = 1'b1;
                    if (state == ST_GET_LEN) begin
                        if (rx_data == 8'h00 || int'(rx_data) > MAX_LEN) begin
                            err_set   = 1'b1;
                            err_cause = ERR_LEN;
                            state_nxt = ST_IDLE;
                        end else begin
                            ld_len    = 1'b1;
                            state_nxt = ST_GET_PL;
                        end
                    end else if (state == ST_GET_PL) begin
                        wr_en = 1'b1;
                        if (idx == len - LW'(1)) state_nxt = ST_GET_CHK;
                    end else begin
                        if (rx_data == chk) begin
                            ok_set    = 1'b1;
                            state_nxt = ST_SEND;
                        end else begin
                            err_set   = 1'b1;
                            err_cause = ERR_CHK;
                            state_nxt = ST_IDLE;
                        end
                    end
                end else if (idle_cnt == TERM) begin
                    err_set   = 1'b1;
                    err_cause = ERR_TIMEOUT;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_SEND: begin
                // Incoming bytes are ignored here; only one frame is held.
                cnt_clr = 1'b1;
                if (pl_ready) begin
                    rd_adv = 1'b1;
                    if (pl_last) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            chk       <= 8'h00;
            idle_cnt  <= '0;
            err_code  <= 2'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= ok_set;
            frame_err <= err_set;
            if (err_set) err_code <= err_cause;

            if (ld_len) begin
                len <= rx_data[LW-1:0];
                chk <= rx_data;
                idx <= '0;
            end else if (wr_en) begin
                chk <= chk ^ rx_data;
                idx <= idx + LW'(1);
            end

            if (cnt_clr)      idle_cnt <= '0;
            else if (cnt_inc) idle_cnt <= idle_cnt + IW'(1);

            if (state != ST_SEND) rd_idx <= '0;
            else if (rd_adv)      rd_idx <= rd_idx + LW'(1);
        end
    end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameters SHALL be: MAX_LEN, default 16, maximum payload bytes per frame (1..255); SOF, default 8'hA5, start-of-frame byte; TIMEOUT_CYC, default 52160, idle clocks allowed between bytes inside a frame.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe that rx_data holds a new received byte.
- rx_data  in  8  received byte, valid when rx_done_tick=1.
- pl_valid  out  1  payload byte available on pl_data.
- pl_data  out  8  payload byte.
- pl_last  out  1  marks the final payload byte of a frame; qualified by pl_valid.
- pl_ready  in  1  consumer accepts the byte when pl_valid && pl_ready.
- frame_ok  out  1  one-cycle pulse: frame passed checksum and was queued for output.
- frame_err  out  1  one-cycle pulse: frame discarded.
- err_code  out  2  cause, valid with frame_err: 1=bad length, 2=checksum, 3=timeout.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 Frame format SHALL be: SOF, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-004 FSM states SHALL be IDLE, GET_LEN, GET_PL, GET_CHK and SEND.
REQ-005 IDLE: a byte equal to SOF SHALL move the FSM to GET_LEN; any other byte SHALL be ignored silently.
REQ-006 GET_LEN, LEN=0 or LEN>MAX_LEN: the parser SHALL pulse frame_err with err_code=1 and return to IDLE.
REQ-007 GET_LEN, valid LEN: the parser SHALL store LEN, seed the running XOR with LEN, clear the byte index and enter GET_PL.
REQ-008 GET_PL: each byte SHALL be written to buffer[index] and XORed into the checksum; after byte LEN the FSM SHALL enter GET_CHK.
REQ-009 GET_CHK, match: the parser SHALL pulse frame_ok in the cycle after the CHK strobe and enter SEND.
REQ-010 GET_CHK, mismatch: the parser SHALL pulse frame_err with err_code=2 and return to IDLE; no payload is emitted.
REQ-011 SEND: pl_valid SHALL be high with pl_data=buffer[rd_idx].
- rd_idx advances only on pl_valid && pl_ready.
- pl_last=1 when rd_idx=LEN-1.
- The handshake on the last byte returns the FSM to IDLE.
REQ-012 pl_data, pl_last and pl_valid SHALL stay stable while pl_valid && !pl_ready.
REQ-013 rx_done_tick in SEND SHALL be dropped; the parser does not buffer a second frame.
REQ-014 In GET_LEN, GET_PL and GET_CHK an idle counter SHALL reset on every rx_done_tick and increment otherwise.
REQ-015 When the idle counter reaches TIMEOUT_CYC-1, the parser SHALL pulse frame_err with err_code=3 and return to IDLE.
REQ-016 A byte strobe in the same cycle as the timeout terminal count SHALL take priority: the byte is consumed and the counter cleared.
REQ-017 frame_ok and frame_err SHALL never be high in the same cycle.
REQ-018 err_code SHALL hold its last value between error pulses.
REQ-019 The byte-index and length counters SHALL be wide enough for MAX_LEN with no wrap-around; the idle counter SHALL be ceil(log2(TIMEOUT_CYC)) bits wide.

Reset
REQ-020 rst SHALL force, asynchronously:
- the FSM to IDLE;
- pl_valid, pl_last, frame_ok, frame_err and busy to 0;
- err_code, pl_data, all counters and the checksum to 0.
REQ-021 Buffer contents SHALL NOT be reset.
REQ-022 Reset asserted mid-frame or mid-SEND SHALL abort with no frame_ok or frame_err pulse; the next valid frame SHALL parse normally.

Structure
REQ-023 The state encoding, the err_code values (1/2/3) and the default SOF SHALL live in a shared uart_pkg constants file, used by this block and by the testbench.
REQ-024 The payload store SHALL be a single sub-module, frame_buf: MAX_LEN x 8 bits, synchronous write, asynchronous read; all other logic stays in the top.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Frame A5 03 11 22 33 CHK=03^11^22^33=03, pl_ready=1: frame_ok pulse, then pl_data 11, 22, 33 on consecutive cycles, pl_last with 33.
- Same frame, CHK=04: frame_err with err_code=2, pl_valid never asserted.
- A5 00, then A5 11 with MAX_LEN=16: two frame_err pulses, err_code=1 each.
- A5 02 11, then silence for TIMEOUT_CYC clocks: frame_err with err_code=3; a following good frame is accepted.
- Good frame, pl_ready toggled 1/0 each cycle, plus an extra rx byte injected during SEND: data held stable while stalled, all bytes in order, injected byte dropped.
- rst pulsed during GET_PL: busy=0 immediately, no ok/err pulse, next good frame parses correctly.
